// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: PC sequencer <-> instruction memory, execute flags and decode register.
interface fetch_sequencer_if;
    logic        hold;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        flag_z;
    logic        flag_n;
    logic [23:0] instr;
    logic        instr_valid;
    logic        ras_err;

    modport master (
        input  hold, imem_data, flag_z, flag_n,
        output imem_addr, instr, instr_valid, ras_err
    );

    modport slave (
        output hold, imem_data, flag_z, flag_n,
        input  imem_addr, instr, instr_valid, ras_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the 8-bit RISC fetch stage: issues {pc, byte0, byte1},
// resolves BR/BRSUB/RET/BRZ/BRN with a return-address stack, and inserts hazard bubbles.
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC     = 8'h00,
    parameter int         RAS_DEPTH    = 4,
    parameter int         FLAG_LAT     = 2,
    parameter int         STALL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);
    localparam int              SP_W       = $clog2(RAS_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL    = SP_W'(RAS_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE     = SP_W'(1);
    localparam logic [7:0]      STALL_INIT = 8'(STALL_CYCLES - 1);
    localparam logic [7:0]      FLAG_INIT  = 8'(FLAG_LAT - 1);

    localparam logic [3:0] OP_BR    = 4'h9;
    localparam logic [3:0] OP_BRC   = 4'hA;
    localparam logic [3:0] OP_BRSUB = 4'hB;
    localparam logic [3:0] OP_RET   = 4'hC;

    typedef enum logic [1:0] {RUN, STALL, BWAIT} state_t;

    state_t          state, state_n;
    logic [7:0]      pc, pc_n;
    logic [7:0]      cnt, cnt_n;
    logic [23:0]     instr_q, instr_n;
    logic            valid_q, valid_n;
    logic            err_q, err_n;
    logic [3:0]      prev_op, prev_op_n;
    logic            prev_valid, prev_valid_n;
    logic [SP_W-1:0] sp, sp_n, top_idx;
    logic            push_en;
    logic [7:0]      ras_mem [2**SP_W];

    logic [3:0]      op;
    logic [7:0]      target;
    logic [7:0]      pc_inc;
    logic            flag_sel;

    assign op       = bus.imem_data[15:12];
    assign target   = bus.imem_data[7:0];
    assign pc_inc   = pc + 8'd2;
    assign top_idx  = sp - SP_ONE;
    // The conditional branch resolves from the issued word, not from a refetch.
    assign flag_sel = instr_q[10] ? bus.flag_n : bus.flag_z;

    function automatic logic is_hazard(input logic [3:0] cur, input logic [3:0] prv);
        case ({cur, prv})
            8'h48, 8'hD5, 8'h5E, 8'hD1, 8'h8F, 8'h8E, 8'hF2, 8'h36: return 1'b1;
            default:                                                  return 1'b0;
        endcase
    endfunction

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        cnt_n        = cnt;
        instr_n      = instr_q;
        valid_n      = 1'b0;
        err_n        = err_q;
        prev_op_n    = prev_op;
        prev_valid_n = prev_valid;
        sp_n         = sp;
        push_en      = 1'b0;

        case (state)
            RUN: begin
                if (prev_valid && is_hazard(op, prev_op)) begin
                    cnt_n        = STALL_INIT;
                    prev_valid_n = 1'b0;
                    if (STALL_INIT != 8'd0) state_n = STALL;
                end else begin
                    instr_n      = {pc, bus.imem_data};
                    valid_n      = 1'b1;
                    prev_op_n    = op;
                    prev_valid_n = 1'b1;
                    pc_n         = pc_inc;
                    case (op)
                        OP_BR: pc_n = target;
                        OP_BRSUB: begin
                            pc_n = target;
                            if (sp == SP_FULL) begin
                                err_n = 1'b1;
                            end else begin
                                push_en = 1'b1;
                                sp_n    = sp + SP_ONE;
                            end
                        end
                        OP_RET: begin
                            if (sp == '0) begin
                                pc_n  = RESET_PC;
                                err_n = 1'b1;
                            end else begin
                                pc_n = ras_mem[top_idx];
                                sp_n = top_idx;
                            end
                        end
                        OP_BRC: begin
                            pc_n    = pc;
                            cnt_n   = FLAG_INIT;
                            state_n = BWAIT;
                        end
                        default: ;
                    endcase
                end
            end

            STALL: begin
                // The hazard cycle itself was the first bubble, so leave on the last count.
                cnt_n = cnt - 8'd1;
                if (cnt <= 8'd1) state_n = RUN;
            end

            BWAIT: begin
                prev_valid_n = 1'b0;
                if (cnt == 8'd0) begin
                    pc_n    = flag_sel ? instr_q[7:0] : pc_inc;
                    state_n = RUN;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end

            default: state_n = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            pc         <= RESET_PC;
            cnt        <= 8'd0;
            instr_q    <= 24'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            prev_op    <= 4'd0;
            prev_valid <= 1'b0;
            sp         <= '0;
        end else if (!bus.hold) begin
            state      <= state_n;
            pc         <= pc_n;
            cnt        <= cnt_n;
            instr_q    <= instr_n;
            valid_q    <= valid_n;
            err_q      <= err_n;
            prev_op    <= prev_op_n;
            prev_valid <= prev_valid_n;
            sp         <= sp_n;
        end
    end

    // NOTE: stack storage has no reset; sp alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (reset && !bus.hold && push_en) ras_mem[sp] <= pc_inc;
    end

    assign bus.imem_addr   = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.ras_err     = err_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer: default instance plus a STALL_CYCLES=2 instance.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic hold;
    logic fz;
    logic fn;
    logic [7:0] mem [256];

    int checks   = 0;
    int failures = 0;
    string tag;

    typedef struct {
        logic        v;
        logic [23:0] ins;
        logic [7:0]  addr;
        logic        err;
    } exp_t;

    exp_t sb1[$];
    exp_t sb2[$];

    always #5 clk = ~clk;

    fetch_sequencer_if bus1 ();
    fetch_sequencer_if bus2 ();

    assign bus1.imem_data = {mem[bus1.imem_addr], mem[bus1.imem_addr + 8'd1]};
    assign bus2.imem_data = {mem[bus2.imem_addr], mem[bus2.imem_addr + 8'd1]};
    assign bus1.hold   = hold;
    assign bus2.hold   = hold;
    assign bus1.flag_z = fz;
    assign bus2.flag_z = fz;
    assign bus1.flag_n = fn;
    assign bus2.flag_n = fn;

    fetch_sequencer #(.RESET_PC(8'h00), .RAS_DEPTH(4), .FLAG_LAT(2), .STALL_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    fetch_sequencer #(.RESET_PC(8'h00), .RAS_DEPTH(4), .FLAG_LAT(2), .STALL_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic ex1(input logic v, input logic [23:0] ins, input logic [7:0] addr, input logic err);
        exp_t e;
        e = '{v: v, ins: ins, addr: addr, err: err};
        sb1.push_back(e);
    endtask

    task automatic ex2(input logic v, input logic [23:0] ins, input logic [7:0] addr, input logic err);
        exp_t e;
        e = '{v: v, ins: ins, addr: addr, err: err};
        sb2.push_back(e);
    endtask

    task automatic put(input logic [7:0] a, input logic [15:0] w);
        mem[a]        = w[15:8];
        mem[a + 8'd1] = w[7:0];
    endtask

    task automatic cmp(input string who, input exp_t e, input logic [7:0] addr,
                       input logic v, input logic [23:0] ins, input logic err);
        check({who, ".addr"}, {24'd0, addr}, {24'd0, e.addr});
        check({who, ".valid"}, {31'd0, v}, {31'd0, e.v});
        if (e.v) check({who, ".instr"}, {8'd0, ins}, {8'd0, e.ins});
        check({who, ".ras_err"}, {31'd0, err}, {31'd0, e.err});
    endtask

    // One clock per step; each DUT output is compared against the head of its scoreboard.
    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                cmp($sformatf("%s.c%0d", tag, i), e, bus1.imem_addr, bus1.instr_valid,
                    bus1.instr, bus1.ras_err);
            end
            if (sb2.size() > 0) begin
                e = sb2.pop_front();
                cmp($sformatf("%s.s2.c%0d", tag, i), e, bus2.imem_addr, bus2.instr_valid,
                    bus2.instr, bus2.ras_err);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check({tag, ".rst.addr"}, {24'd0, bus1.imem_addr}, 32'h00);
        check({tag, ".rst.valid"}, {31'd0, bus1.instr_valid}, 32'd0);
        check({tag, ".rst.instr"}, {8'd0, bus1.instr}, 32'd0);
        check({tag, ".rst.ras_err"}, {31'd0, bus1.ras_err}, 32'd0);
        for (int i = 0; i < 256; i++) mem[i] = (i % 2 == 0) ? 8'h70 : 8'h00;
    endtask

    task automatic release_reset();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        hold  = 1'b0;
        fz    = 1'b0;
        fn    = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #1;

        tag = "straight";
        do_reset();
        put(8'h06, 16'h90FC);
        release_reset();
        ex1(1, 24'h007000, 8'h02, 0);
        ex1(1, 24'h027000, 8'h04, 0);
        ex1(1, 24'h047000, 8'h06, 0);
        ex1(1, 24'h0690FC, 8'hFC, 0);
        ex1(1, 24'hFC7000, 8'hFE, 0);
        ex1(1, 24'hFE7000, 8'h00, 0);
        ex1(1, 24'h007000, 8'h02, 0);
        run(7);

        tag = "hazard";
        do_reset();
        put(8'h00, 16'h9010);
        put(8'h10, 16'h8000);
        put(8'h12, 16'h4000);
        release_reset();
        ex1(1, 24'h009010, 8'h10, 0);
        ex1(1, 24'h108000, 8'h12, 0);
        ex1(0, 24'h0,      8'h12, 0);
        ex1(1, 24'h124000, 8'h14, 0);
        ex1(1, 24'h147000, 8'h16, 0);
        ex2(1, 24'h009010, 8'h10, 0);
        ex2(1, 24'h108000, 8'h12, 0);
        ex2(0, 24'h0,      8'h12, 0);
        ex2(0, 24'h0,      8'h12, 0);
        ex2(1, 24'h124000, 8'h14, 0);
        run(5);

        tag = "call_ret";
        do_reset();
        put(8'h00, 16'h9020);
        put(8'h20, 16'hB03A);
        put(8'h3A, 16'hC000);
        put(8'h22, 16'hB060);
        release_reset();
        ex1(1, 24'h009020, 8'h20, 0);
        ex1(1, 24'h20B03A, 8'h3A, 0);
        ex1(1, 24'h3AC000, 8'h22, 0);
        ex1(1, 24'h22B060, 8'h60, 0);
        ex1(1, 24'h607000, 8'h62, 0);
        run(5);

        tag = "ret_empty";
        do_reset();
        put(8'h00, 16'hC000);
        release_reset();
        ex1(1, 24'h00C000, 8'h00, 1);
        run(1);

        tag = "nested";
        do_reset();
        put(8'h00, 16'hB010);
        put(8'h10, 16'hB020);
        put(8'h20, 16'hB030);
        put(8'h30, 16'hB040);
        put(8'h40, 16'hB050);
        put(8'h50, 16'hC000);
        put(8'h32, 16'hC000);
        put(8'h22, 16'hC000);
        put(8'h12, 16'hC000);
        put(8'h02, 16'hC000);
        release_reset();
        ex1(1, 24'h00B010, 8'h10, 0);
        ex1(1, 24'h10B020, 8'h20, 0);
        ex1(1, 24'h20B030, 8'h30, 0);
        ex1(1, 24'h30B040, 8'h40, 0);
        ex1(1, 24'h40B050, 8'h50, 1);
        ex1(1, 24'h50C000, 8'h32, 1);
        ex1(1, 24'h32C000, 8'h22, 1);
        ex1(1, 24'h22C000, 8'h12, 1);
        ex1(1, 24'h12C000, 8'h02, 1);
        ex1(1, 24'h02C000, 8'h00, 1);
        run(10);

        tag = "brz_taken";
        do_reset();
        put(8'h00, 16'h9030);
        put(8'h30, 16'hA040);
        fz = 1'b0;
        fn = 1'b0;
        release_reset();
        ex1(1, 24'h009030, 8'h30, 0);
        ex1(1, 24'h30A040, 8'h30, 0);
        ex1(0, 24'h0,      8'h30, 0);
        run(3);
        fz = 1'b1;
        ex1(0, 24'h0,      8'h40, 0);
        ex1(1, 24'h407000, 8'h42, 0);
        run(2);

        tag = "brz_not";
        do_reset();
        put(8'h00, 16'h9030);
        put(8'h30, 16'hA040);
        fz = 1'b1;
        release_reset();
        ex1(1, 24'h009030, 8'h30, 0);
        ex1(1, 24'h30A040, 8'h30, 0);
        ex1(0, 24'h0,      8'h30, 0);
        run(3);
        fz = 1'b0;
        ex1(0, 24'h0,      8'h32, 0);
        ex1(1, 24'h327000, 8'h34, 0);
        run(2);

        tag = "brn_taken";
        do_reset();
        put(8'h00, 16'h9030);
        put(8'h30, 16'hA440);
        fz = 1'b0;
        fn = 1'b0;
        release_reset();
        ex1(1, 24'h009030, 8'h30, 0);
        ex1(1, 24'h30A440, 8'h30, 0);
        ex1(0, 24'h0,      8'h30, 0);
        run(3);
        fn = 1'b1;
        ex1(0, 24'h0,      8'h40, 0);
        ex1(1, 24'h407000, 8'h42, 0);
        run(2);
        fn = 1'b0;

        tag = "hold";
        do_reset();
        put(8'h00, 16'h9030);
        put(8'h30, 16'hA040);
        fz = 1'b1;
        release_reset();
        ex1(1, 24'h009030, 8'h30, 0);
        ex1(1, 24'h30A040, 8'h30, 0);
        run(2);
        hold = 1'b1;
        ex1(1, 24'h30A040, 8'h30, 0);
        ex1(1, 24'h30A040, 8'h30, 0);
        ex1(1, 24'h30A040, 8'h30, 0);
        run(3);
        hold = 1'b0;
        ex1(0, 24'h0,      8'h30, 0);
        ex1(0, 24'h0,      8'h40, 0);
        ex1(1, 24'h407000, 8'h42, 0);
        run(3);

        tag = "reset_bwait";
        do_reset();
        put(8'h00, 16'h9030);
        put(8'h30, 16'hA040);
        fz = 1'b0;
        release_reset();
        ex1(1, 24'h009030, 8'h30, 0);
        ex1(1, 24'h30A040, 8'h30, 0);
        run(2);
        tag = "reset_bwait.abort";
        do_reset();
        put(8'h00, 16'h9030);
        put(8'h30, 16'hA040);
        release_reset();
        ex1(1, 24'h009030, 8'h30, 0);
        run(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
